// File: rtl/wide_add_sequencer.sv
// Byte-serial WIDTH-bit adder: one shared 8-bit ripple adder, LSB byte first, carry chained in a register.
// Optional subtract mode is compiled in with `define SUB_EN.
module wide_add_sequencer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  cin,
    input  logic                  op_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int unsigned WIDTH = 8 * NBYTES;
    localparam int unsigned IDXW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;

    logic [WIDTH-1:0]  b_eff_c;
    logic              cin_eff_c;
    logic [7:0]        a_byte_c;
    logic [7:0]        b_byte_c;
    logic [8:0]        byte_sum_c;

    // B is stored already inverted for subtraction, so the datapath is always an add
`ifdef SUB_EN
    assign b_eff_c   = op_sub ? ~op_b : op_b;
    assign cin_eff_c = op_sub ? 1'b1 : cin;
`else
    logic unused_op_sub_c;
    assign unused_op_sub_c = op_sub;
    assign b_eff_c   = op_b;
    assign cin_eff_c = cin;
`endif

    assign a_byte_c   = a_reg[{idx, 3'b000} +: 8];
    assign b_byte_c   = b_reg[{idx, 3'b000} +: 8];
    assign byte_sum_c = 9'(a_byte_c) + 9'(b_byte_c) + 9'(carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= op_a;
                        b_reg    <= b_eff_c;
                        carry    <= cin_eff_c;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[{idx, 3'b000} +: 8] <= byte_sum_c[7:0];
                    carry <= byte_sum_c[8];
                    if (idx == LAST_IDX) begin
                        // Sum MSB comes straight from the adder; the sum register lags a cycle
                        cout      <= byte_sum_c[8];
                        ovf       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &
                                     (byte_sum_c[7] != a_reg[WIDTH-1]);
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= IDXW'(idx + 1'b1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (NBYTES=4): reset, carry ripple, overflow, backpressure, subtract.
module tb_wide_add_sequencer;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned WIDTH  = 8 * NBYTES;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;

    wide_add_sequencer #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request from IDLE; returns after the acceptance edge
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        cin      = c;
        op_sub   = s;
        tick();
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        cin      = ~c;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(NBYTES));
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s, input logic [WIDTH-1:0] esum,
                          input logic ecout, input logic eovf);
        launch(a, b, c, s);
        check({tag, "_busy"}, 64'(in_ready), 64'(0));
        wait_done(tag);
        check({tag, "_sum"},  64'(sum),  64'(esum));
        check({tag, "_cout"}, 64'(cout), 64'(ecout));
        check({tag, "_ovf"},  64'(ovf),  64'(eovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 64'(in_ready),  64'(1));
        check({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("por_in_ready",  64'(in_ready),  64'(1));
        check("por_out_valid", 64'(out_valid), 64'(0));
        check("por_sum",       64'(sum),       64'(0));

        // Reset in the middle of RUN after two bytes have been written
        launch(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum",       64'(sum),       64'(0));
        check("rst_cout",      64'(cout),      64'(0));
        check("rst_ovf",       64'(ovf),       64'(0));

        // out_ready outside DONE must not disturb IDLE
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stray_ready", 64'(in_ready), 64'(1));

        run_op("basic",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("sovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("novf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        run_op("mixed",  32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0);

        // Backpressure with a competing request held throughout
        launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_done("bp");
        in_valid = 1'b1;
        op_a     = 32'h0000_0003;
        op_b     = 32'h0000_0004;
        cin      = 1'b0;
        op_sub   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_sum",   64'(sum),       64'(32'h2345_6789));
            check("bp_hold_cout",  64'(cout),      64'(0));
            check("bp_hold_ovf",   64'(ovf),       64'(0));
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_ready", 64'(in_ready),  64'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ready", 64'(in_ready),  64'(1));
        check("bp_release_valid", 64'(out_valid), 64'(0));
        tick();
        in_valid = 1'b0;
        check("bp_accept_busy", 64'(in_ready), 64'(0));
        wait_done("bp2");
        check("bp2_sum", 64'(sum), 64'(32'h0000_0007));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

`ifdef SUB_EN
        run_op("sub", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_nb", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`else
        run_op("sub", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
